// File: rtl/uart_cmd_dispatcher.sv
// Frames a UART byte stream into motor command packets and holds one pending command per channel.
// Define CMD_CHECKSUM_EN to require a trailing XOR checksum byte (mismatch reported on err_index).
module uart_cmd_dispatcher #(
    parameter int NUM_MOTORS  = 10,
    parameter int DIV_W       = 15,
    parameter int STEP_W      = 17,
    parameter int TIMEOUT_CYC = 2400
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic [NUM_MOTORS-1:0]        mtr_ready,
    output logic [NUM_MOTORS-1:0]        load,
    output logic [NUM_MOTORS*DIV_W-1:0]  div_out,
    output logic [NUM_MOTORS*STEP_W-1:0] step_out,
    output logic [NUM_MOTORS-1:0]        pending,
    output logic                         err_index,
    output logic                         err_overflow,
    output logic                         err_timeout,
    output logic [1:0]                   dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`ifdef CMD_CHECKSUM_EN
    localparam logic [2:0] LAST_CNT = 3'd4;
`else
    localparam logic [2:0] LAST_CNT = 3'd3;
`endif

    logic [1:0]            state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic                  bad_q, bad_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [31:0]           payload_q, payload_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [NUM_MOTORS-1:0] pending_q, pending_d;
    logic [NUM_MOTORS-1:0] load_q, load_d;
    logic [NUM_MOTORS-1:0] sel, wr_vec;
    logic [31:0]           slot_q [NUM_MOTORS];
    logic                  err_index_q, err_index_d;
    logic                  err_overflow_q, err_overflow_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  reject;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  csum_ok_q, csum_ok_d;
    assign reject = bad_q | ~csum_ok_q;
`else
    assign reject = bad_q;
`endif

    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            sel[i] = (idx_q == 4'(i));
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        bad_d          = bad_q;
        cnt_d          = cnt_q;
        payload_d      = payload_q;
        tmo_d          = '0;
        wr_vec         = '0;
        err_index_d    = 1'b0;
        err_overflow_d = 1'b0;
        err_timeout_d  = 1'b0;
`ifdef CMD_CHECKSUM_EN
        csum_d         = csum_q;
        csum_ok_d      = csum_ok_q;
`endif
        case (state_q)
            S_DATA: begin
                if (rx_valid) begin
                    cnt_d = cnt_q + 3'd1;
`ifdef CMD_CHECKSUM_EN
                    if (cnt_q != LAST_CNT) payload_d = {rx_data, payload_q[31:8]};
                    csum_d    = csum_q ^ rx_data;
                    csum_ok_d = (csum_q == rx_data);
`else
                    payload_d = {rx_data, payload_q[31:8]};
`endif
                    if (cnt_q == LAST_CNT) state_d = S_COMMIT;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                // COMMIT also accepts a new byte0, so it shares the IDLE transition.
                if (state_q == S_COMMIT) begin
                    if (reject) err_index_d = 1'b1;
                    else if (!(|(pending_q & sel)) || (|(load_q & sel))) wr_vec = sel;
                    else err_overflow_d = 1'b1;
                end
                if (rx_valid) begin
                    idx_d   = rx_data[3:0];
                    bad_d   = (rx_data[7:4] != 4'd0) || ({1'b0, rx_data[3:0]} >= 5'(NUM_MOTORS));
                    cnt_d   = 3'd0;
                    state_d = S_DATA;
`ifdef CMD_CHECKSUM_EN
                    csum_d  = rx_data;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // A same-edge commit re-arms pending, so the new data gets its own load pulse.
    assign pending_d = wr_vec | (pending_q & ~load_q);
    assign load_d    = pending_d & mtr_ready;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            bad_q          <= 1'b0;
            cnt_q          <= '0;
            payload_q      <= '0;
            tmo_q          <= '0;
            pending_q      <= '0;
            load_q         <= '0;
            err_index_q    <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            for (int i = 0; i < NUM_MOTORS; i++) slot_q[i] <= '0;
`ifdef CMD_CHECKSUM_EN
            csum_q         <= '0;
            csum_ok_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            bad_q          <= bad_d;
            cnt_q          <= cnt_d;
            payload_q      <= payload_d;
            tmo_q          <= tmo_d;
            pending_q      <= pending_d;
            load_q         <= load_d;
            err_index_q    <= err_index_d;
            err_overflow_q <= err_overflow_d;
            err_timeout_q  <= err_timeout_d;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                if (wr_vec[i]) slot_q[i] <= payload_q;
            end
`ifdef CMD_CHECKSUM_EN
            csum_q         <= csum_d;
            csum_ok_q      <= csum_ok_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_out
        assign div_out[g*DIV_W +: DIV_W]    = slot_q[g][DIV_W-1:0];
        assign step_out[g*STEP_W +: STEP_W] = slot_q[g][DIV_W +: STEP_W];
    end

    assign load         = load_q;
    assign pending      = pending_q;
    assign err_index    = err_index_q;
    assign err_overflow = err_overflow_q;
    assign err_timeout  = err_timeout_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Bench for uart_cmd_dispatcher: directed scenarios plus random packets against a packet-level model.
module tb_uart_cmd_dispatcher;

    localparam int NM = 10;
    localparam int DW = 15;
    localparam int SW = 17;
    localparam int TO = 2400;
`ifdef CMD_CHECKSUM_EN
    localparam int PKT = 6;
`else
    localparam int PKT = 5;
`endif

    logic              CLK = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [NM-1:0]     mtr_ready;
    logic [NM-1:0]     load;
    logic [NM*DW-1:0]  div_out;
    logic [NM*SW-1:0]  step_out;
    logic [NM-1:0]     pending;
    logic              err_index, err_overflow, err_timeout;
    logic [1:0]        dbg_state;

    uart_cmd_dispatcher #(.NUM_MOTORS(NM), .DIV_W(DW), .STEP_W(SW), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .mtr_ready(mtr_ready),
        .load(load), .div_out(div_out), .step_out(step_out), .pending(pending),
        .err_index(err_index), .err_overflow(err_overflow), .err_timeout(err_timeout),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Packets are collected as byte lists; decisions follow the command rules directly.
    logic [31:0]   m_slot [NM];
    logic [NM-1:0] m_pend = '0;
    logic [NM-1:0] m_load = '0;
    logic [NM-1:0] m_wr;
    logic [7:0]    m_buf[$];
    bit            m_commit = 0;
    int            m_idle = 0;
    logic          m_eidx = 0, m_eovf = 0, m_etmo = 0;
    logic [35:0]   exp_q[$];
    int            m_idx;
    bit            m_bad;
    logic [31:0]   m_pl;

    initial for (int i = 0; i < NM; i++) m_slot[i] = '0;

    always @(posedge CLK) begin
        if (reset) begin
            m_buf.delete(); exp_q.delete();
            m_commit = 0; m_idle = 0; m_pend = '0; m_load = '0;
            m_eidx = 0; m_eovf = 0; m_etmo = 0;
            for (int i = 0; i < NM; i++) m_slot[i] = '0;
        end else begin
            m_eidx = 0; m_eovf = 0; m_etmo = 0; m_wr = '0;
            if (m_commit) begin
                m_idx = int'(m_buf[0]);
                m_bad = (m_idx >= NM);
                m_pl  = {m_buf[4], m_buf[3], m_buf[2], m_buf[1]};
`ifdef CMD_CHECKSUM_EN
                if ((m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4]) != m_buf[5]) m_bad = 1;
`endif
                if (m_bad) m_eidx = 1;
                else if (!m_pend[m_idx] || m_load[m_idx]) begin
                    m_slot[m_idx] = m_pl;
                    m_wr[m_idx] = 1'b1;
                end else m_eovf = 1;
                m_buf.delete();
                m_commit = 0;
            end
            for (int i = 0; i < NM; i++) begin
                if (m_wr[i]) m_pend[i] = 1'b1;
                else if (m_load[i]) m_pend[i] = 1'b0;
            end
            m_load = m_pend & mtr_ready;
            for (int i = 0; i < NM; i++)
                if (m_load[i]) exp_q.push_back({4'(i), m_slot[i]});
            if (rx_valid) begin
                m_idle = 0;
                m_buf.push_back(rx_data);
                if (m_buf.size() == PKT) m_commit = 1;
            end else if (m_buf.size() > 0 && !m_commit) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_etmo = 1;
                    m_buf.delete();
                    m_idle = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    bit            chk_en = 0;
    int            n_idx = 0, n_ovf = 0, n_tmo = 0, n_loads = 0;
    logic [NM*DW-1:0] e_div;
    logic [NM*SW-1:0] e_step;
    logic [35:0]   sb_e;

    always @(negedge CLK) begin
        if (chk_en && !reset) begin
            for (int i = 0; i < NM; i++) begin
                e_div[i*DW +: DW]  = m_slot[i][DW-1:0];
                e_step[i*SW +: SW] = m_slot[i][DW +: SW];
            end
            check("load", load, m_load);
            check("pending", pending, m_pend);
            check("err_bits", {err_index, err_overflow, err_timeout}, {m_eidx, m_eovf, m_etmo});
            check("div_out", div_out, e_div);
            check("step_out", step_out, e_step);
            for (int i = 0; i < NM; i++) begin
                if (load[i]) begin
                    n_loads++;
                    if (exp_q.size() == 0) check("sb_unexpected_load", 1, 0);
                    else begin
                        sb_e = exp_q.pop_front();
                        check("sb_delivery", {4'(i), step_out[i*SW +: SW], div_out[i*DW +: DW]}, sb_e);
                    end
                end
            end
            n_idx += int'(err_index);
            n_ovf += int'(err_overflow);
            n_tmo += int'(err_timeout);
        end
    end

    // ---------------- driver tasks ----------------
    bit         rand_rdy = 0;
    logic [7:0] pkt_b [6];

    always @(negedge CLK)
        if (rand_rdy)
            mtr_ready = ($urandom_range(3, 0) == 0) ? '1 : NM'($urandom & $urandom);

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic make_pkt(input logic [7:0] idx, input logic [31:0] pl, input bit corrupt);
        pkt_b[0] = idx;
        pkt_b[1] = pl[7:0];
        pkt_b[2] = pl[15:8];
        pkt_b[3] = pl[23:16];
        pkt_b[4] = pl[31:24];
        pkt_b[5] = idx ^ pl[7:0] ^ pl[15:8] ^ pl[23:16] ^ pl[31:24] ^ {7'd0, corrupt};
    endtask

    task automatic send_pkt(input logic [7:0] idx, input logic [31:0] pl, input int gap_max, input bit corrupt);
        make_pkt(idx, pl, corrupt);
        for (int k = 0; k < PKT; k++) begin
            send_byte(pkt_b[k]);
            if (k < PKT - 1 && gap_max > 0) idle($urandom_range(gap_max, 0));
        end
    endtask

    task automatic wait_load(input int ch, input string tag);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (load[ch]) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_seen"}, seen, 1);
    endtask

    // ---------------- stimulus ----------------
    int          snap;
    logic [31:0] pa, pb;

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; mtr_ready = '0;
        idle(3);
        check("rst_load", load, 0);
        check("rst_pending", pending, 0);
        check("rst_errs", {err_index, err_overflow, err_timeout}, 0);
        check("rst_div", div_out, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;
        chk_en = 1;
        idle(2);

        // basic delivery on channel 3
        send_pkt(8'h03, 32'h0000_1234, 0, 0);
        idle(3);
        check("c3_pending_set", pending[3], 1);
        snap = n_loads;
        mtr_ready[3] = 1'b1;
        wait_load(3, "c3_load");
        check("c3_div", div_out[3*DW +: DW], 15'h1234);
        check("c3_step", step_out[3*SW +: SW], 0);
        idle(3);
        check("c3_one_pulse", n_loads - snap, 1);
        check("c3_pending_clr", pending[3], 0);
        mtr_ready = '0;

        // field split at the boundary
        mtr_ready[0] = 1'b1;
        send_pkt(8'h00, 32'hFFFF_8005, 1, 0);
        wait_load(0, "c0_load");
        check("c0_div", div_out[0 +: DW], 15'h0005);
        check("c0_step", step_out[0 +: SW], 17'h1FFFF);
        idle(2);
        mtr_ready = '0;

        // overflow keeps the first command
        pa = 32'h0000_0ABC;
        send_pkt(8'h07, pa, 0, 0);
        idle(2);
        snap = n_ovf;
        send_pkt(8'h07, 32'h0000_0DEF, 0, 0);
        idle(3);
        check("c7_overflow", n_ovf - snap, 1);
        mtr_ready[7] = 1'b1;
        wait_load(7, "c7_load");
        check("c7_div_first", div_out[7*DW +: DW], pa[DW-1:0]);
        idle(2);
        mtr_ready = '0;

        // bad index consumes the whole packet
        snap = n_idx;
        send_pkt(8'h0C, $urandom, 0, 0);
        idle(3);
        check("bad_idx_err", n_idx - snap, 1);
        check("bad_idx_pending", pending, 0);
        pa = 32'h1234_5678;
        mtr_ready[5] = 1'b1;
        send_pkt(8'h05, pa, 0, 0);
        wait_load(5, "c5_load");
        check("c5_div", div_out[5*DW +: DW], pa[DW-1:0]);
        check("c5_step", step_out[5*SW +: SW], pa[31:DW]);
        idle(2);
        mtr_ready = '0;

        // inter-byte timeout, then recovery
        send_byte(8'h01);
        send_byte(8'h11);
        snap = n_tmo;
        idle(TO + 3);
        check("timeout_pulse", n_tmo - snap, 1);
        pa = 32'hCAFE_0001;
        mtr_ready[1] = 1'b1;
        send_pkt(8'h01, pa, 0, 0);
        wait_load(1, "c1_load");
        check("c1_div", div_out[1*DW +: DW], pa[DW-1:0]);
        idle(2);
        mtr_ready = '0;

        // commit on the same edge as a load
        pa = 32'h0001_0111;
        pb = 32'h0002_0222;
        send_pkt(8'h02, pa, 0, 0);
        idle(3);
        check("se_pend_a", pending[2], 1);
        make_pkt(8'h02, pb, 0);
        for (int k = 0; k < PKT - 1; k++) send_byte(pkt_b[k]);
        rx_data = pkt_b[PKT-1];
        rx_valid = 1'b1;
        mtr_ready[2] = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        check("se_load_old", load[2], 1);
        check("se_div_old", div_out[2*DW +: DW], pa[DW-1:0]);
        @(negedge CLK);
        check("se_pend_kept", pending[2], 1);
        check("se_load_new", load[2], 1);
        check("se_div_new", div_out[2*DW +: DW], pb[DW-1:0]);
        @(negedge CLK);
        check("se_done", {load[2], pending[2]}, 0);
        mtr_ready = '0;

        // reset mid-packet drops the partial command
        send_byte(8'h04);
        send_byte(8'h55);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        snap = n_loads;
        mtr_ready[4] = 1'b1;
        idle(5);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_noload", n_loads - snap, 0);
        mtr_ready = '0;

        // random traffic
        rand_rdy = 1;
        for (int p = 0; p < 250; p++) begin
            logic [7:0] ix;
            ix = ($urandom_range(9, 0) == 0) ? 8'($urandom_range(255, 10)) : 8'($urandom_range(NM - 1, 0));
            if ($urandom_range(59, 0) == 0) begin
                send_byte(ix);
                send_byte(8'($urandom));
                idle(TO + 3);
            end else begin
                send_pkt(ix, $urandom, 2, ($urandom_range(9, 0) == 0));
            end
            idle($urandom_range(4, 0));
        end
        rand_rdy = 0;
        mtr_ready = '1;
        idle(10);
        check("final_pending", pending, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
